// File: rtl/multicore_memory_arbiter.sv
// Round-robin arbiter that shares one RAM port among NCORES cores, each with an instruction and a data port.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts an XFER stuck for TIMEOUT cycles and pulses arb_err.
module multicore_memory_arbiter #(
   parameter int  NCORES  = 2,
   parameter int  AW      = 32,
   parameter int  DW      = 32,
   parameter int  TIMEOUT = 64,
   localparam int CW      = (NCORES > 1) ? $clog2(NCORES) : 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NCORES-1:0]    iREN,
   input  logic [NCORES-1:0]    dREN,
   input  logic [NCORES-1:0]    dWEN,
   input  logic [NCORES*AW-1:0] iaddr,
   input  logic [NCORES*AW-1:0] daddr,
   input  logic [NCORES*DW-1:0] dstore,
   output logic [NCORES-1:0]    iwait,
   output logic [NCORES-1:0]    dwait,
   output logic [NCORES*DW-1:0] iload,
   output logic [NCORES*DW-1:0] dload,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [AW-1:0]      ramaddr,
   output logic [DW-1:0]      ramstore,
   input  logic [DW-1:0]      ramload,
   input  logic [1:0]         ramstate,
   output logic               arb_err,
   output logic               dbg_state,
   output logic [CW-1:0]      dbg_rr_ptr
);

   // Handshake: a core holds its request level-high until its wait drops low for exactly one
   // cycle (the completion cycle); dropping the request earlier abandons the access silently.
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
   typedef enum logic [1:0] {T_NONE = 2'd0, T_DR = 2'd1, T_DW = 2'd2, T_IR = 2'd3} gnt_t;

   state_t            state, state_nx;
   gnt_t              gnt_type, gnt_type_nx, pick_type;
   logic [CW-1:0]     rr_ptr, rr_ptr_nx, gnt_core, gnt_core_nx, pick_core, ptr_after, cidx;
   logic [NCORES-1:0] req;
   logic              pick_valid, live, abort, done;
   int                gsel;

   assign req       = dREN | dWEN | iREN;
   assign gsel      = int'(gnt_core);
   assign ptr_after = (gsel == NCORES - 1) ? '0 : gnt_core + 1'b1;

   // Scan from rr_ptr upward (wrapping) for the first requesting core.
   always_comb begin
      pick_valid = 1'b0;
      pick_core  = '0;
      cidx       = '0;
      for (int i = 0; i < NCORES; i++) begin
         cidx = CW'((int'(rr_ptr) + i) % NCORES);
         if (!pick_valid && req[cidx]) begin
            pick_valid = 1'b1;
            pick_core  = cidx;
         end
      end
      pick_type = T_IR;
      if (dREN[pick_core])      pick_type = T_DR;
      else if (dWEN[pick_core]) pick_type = T_DW;
   end

   always_comb begin
      case (gnt_type)
         T_DR:    live = dREN[gnt_core];
         T_DW:    live = dWEN[gnt_core];
         T_IR:    live = iREN[gnt_core];
         default: live = 1'b0;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;

   // Cleared while idle, so every XFER starts counting from zero.
   always_ff @(posedge CLK) begin
      if (RST || state == IDLE)        tmo_cnt <= '0;
      else if (ramstate != RAM_ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign abort = (state == XFER) && (tmo_cnt == TW'(TIMEOUT));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign abort          = 1'b0;
`endif

   assign done    = (state == XFER) && !abort && live && (ramstate == RAM_ACCESS);
   assign arb_err = abort;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         gnt_core <= '0;
         gnt_type <= T_NONE;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_ptr_nx;
         gnt_core <= gnt_core_nx;
         gnt_type <= gnt_type_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      gnt_core_nx = gnt_core;
      gnt_type_nx = gnt_type;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nx    = XFER;
               gnt_core_nx = pick_core;
               gnt_type_nx = pick_type;
            end
         end
         XFER: begin
            if (abort) begin
               state_nx  = IDLE;
               rr_ptr_nx = ptr_after;
            end else if (!live) begin
               state_nx = IDLE;
            end else if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
               state_nx  = IDLE;
               rr_ptr_nx = ptr_after;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // RAM controls follow the granted core's live signals, so a withdrawn request drops them at once.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      if (state == XFER) begin
         case (gnt_type)
            T_DR: begin
               ramREN  = dREN[gnt_core];
               ramaddr = daddr[gsel*AW +: AW];
            end
            T_DW: begin
               ramWEN   = dWEN[gnt_core];
               ramaddr  = daddr[gsel*AW +: AW];
               ramstore = dstore[gsel*DW +: DW];
            end
            T_IR: begin
               ramREN  = iREN[gnt_core];
               ramaddr = iaddr[gsel*AW +: AW];
            end
            default: ;
         endcase
         if (done) begin
            if (gnt_type == T_IR) iwait[gnt_core] = 1'b0;
            else                  dwait[gnt_core] = 1'b0;
         end
      end
   end

   assign iload      = {NCORES{ramload}};
   assign dload      = {NCORES{ramload}};
   assign dbg_state  = (state == XFER);
   assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_multicore_memory_arbiter.sv
// Self-checking bench for multicore_memory_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_multicore_memory_arbiter;

   localparam int NC  = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;
   localparam int CW  = (NC > 1) ? $clog2(NC) : 1;
   localparam int QW  = 1 + AW + DW;
   localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

   logic              clk, rst;
   logic [NC-1:0]     iren, dren, dwen, iwait, dwait;
   logic [NC*AW-1:0]  iaddr, daddr;
   logic [NC*DW-1:0]  dstore, iload, dload;
   logic              ram_ren, ram_wen, arb_err, dbg_state;
   logic [AW-1:0]     ramaddr;
   logic [DW-1:0]     ramstore, ramload;
   logic [1:0]        ramstate;
   logic [CW-1:0]     dbg_rr_ptr;

   int                vectors = 0;
   int                miscompares = 0;
   logic [QW-1:0]     exp_q[$];

   multicore_memory_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .CLK(clk), .RST(rst), .iREN(iren), .dREN(dren), .dWEN(dwen),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
      .iload(iload), .dload(dload), .ramREN(ram_ren), .ramWEN(ram_wen),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .arb_err(arb_err), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   // Drivers: inputs change on the falling edge, outputs are sampled 1 ns later.
   task automatic clear_inputs();
      iren = '0; dren = '0; dwen = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramstate = RS_FREE;
      ramload = $urandom;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      dren = '1;
      ramstate = RS_ACCESS;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if ({ram_ren, ram_wen, iwait, dwait, arb_err} !== 7'b00_11_11_0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected %b", {ram_ren, ram_wen, iwait, dwait, arb_err}, 7'b00_11_11_0);
      end
      vectors++;
      if ({ramaddr, ramstore} !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: got addr %h store %h expected 0", ramaddr, ramstore);
      end
      vectors++;
      if ({dbg_state, dbg_rr_ptr} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got state %b ptr %0d expected 0/0", dbg_state, dbg_rr_ptr);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_reset_mid_xfer();
      do_reset();
      dren[0] = 1'b1;
      daddr[0 +: AW] = 32'h10;
      ramstate = RS_BUSY;
      #1; @(negedge clk);
      #1;
      vectors++;
      if ({ram_ren, dbg_state} !== 2'b11) begin
         miscompares++;
         $display("FAIL rst_mid_xfer1: got ren/state %b expected 11", {ram_ren, dbg_state});
      end
      @(negedge clk);
      rst = 1'b1;
      #1; @(negedge clk);
      #1;
      vectors++;
      if ({ram_ren, iwait, dwait, dbg_rr_ptr, dbg_state} !== {1'b0, 4'b1111, CW'(0), 1'b0}) begin
         miscompares++;
         $display("FAIL rst_mid_xfer: got %b expected %b", {ram_ren, iwait, dwait, dbg_rr_ptr, dbg_state},
                  {1'b0, 4'b1111, CW'(0), 1'b0});
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] exp_addr[3];
      logic [1:0]    exp_iw[6];
      exp_addr = '{32'h100, 32'h200, 32'h100};
      exp_iw   = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
      do_reset();
      iren = 2'b11;
      iaddr[0 +: AW]  = 32'h100;
      iaddr[AW +: AW] = 32'h200;
      ramstate = RS_ACCESS;
      for (int c = 0; c < 6; c++) begin
         #1;
         vectors++;
         if ({iwait, dwait} !== {exp_iw[c], 2'b11}) begin
            miscompares++;
            $display("FAIL rr_wait c%0d: got %b expected %b", c, {iwait, dwait}, {exp_iw[c], 2'b11});
         end
         vectors++;
         if (c % 2 == 1) begin
            if ({ram_ren, ramaddr} !== {1'b1, exp_addr[c/2]}) begin
               miscompares++;
               $display("FAIL rr_addr c%0d: got %b/%h expected 1/%h", c, ram_ren, ramaddr, exp_addr[c/2]);
            end
         end else if (ram_ren !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_idle c%0d: got ren %b expected 0", c, ram_ren);
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_type_priority();
      do_reset();
      dwen[1] = 1'b1;
      iren[1] = 1'b1;
      daddr[AW +: AW]  = 32'h40;
      dstore[DW +: DW] = 32'hDEADBEEF;
      iaddr[AW +: AW]  = 32'h80;
      ramstate = RS_BUSY;
      #1; @(negedge clk);
      #1;
      vectors++;
      if ({ram_ren, ram_wen, ramaddr, ramstore, dwait} !== {2'b01, 32'h40, 32'hDEADBEEF, 2'b11}) begin
         miscompares++;
         $display("FAIL prio_write: got ren %b wen %b addr %h store %h dwait %b", ram_ren, ram_wen, ramaddr, ramstore, dwait);
      end
      @(negedge clk);
      ramstate = RS_ACCESS;
      #1;
      vectors++;
      if ({iwait, dwait} !== 4'b11_01) begin
         miscompares++;
         $display("FAIL prio_done: got %b expected 1101", {iwait, dwait});
      end
      @(negedge clk);
      dwen[1] = 1'b0;
      ramstate = RS_BUSY;
      #1;
      vectors++;
      if ({dbg_state, dbg_rr_ptr} !== {1'b0, CW'(0)}) begin
         miscompares++;
         $display("FAIL prio_gap: got state %b ptr %0d expected 0/0", dbg_state, dbg_rr_ptr);
      end
      @(negedge clk);
      ramstate = RS_ACCESS;
      #1;
      vectors++;
      if ({ram_ren, ram_wen, ramaddr, iwait, dwait} !== {2'b10, 32'h80, 4'b01_11}) begin
         miscompares++;
         $display("FAIL prio_ifetch: got ren %b wen %b addr %h waits %b", ram_ren, ram_wen, ramaddr, {iwait, dwait});
      end
      @(negedge clk);
      clear_inputs();
      dren[0] = 1'b1;
      dwen[0] = 1'b1;
      daddr[0 +: AW] = 32'h44;
      ramstate = RS_BUSY;
      #1; @(negedge clk);
      ramstate = RS_ACCESS;
      #1;
      vectors++;
      if ({ram_ren, ram_wen, ramaddr, dwait} !== {2'b10, 32'h44, 2'b10}) begin
         miscompares++;
         $display("FAIL read_over_write: got ren %b wen %b addr %h dwait %b", ram_ren, ram_wen, ramaddr, dwait);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_withdrawal();
      do_reset();
      dren[0] = 1'b1;
      daddr[0 +: AW] = 32'h30;
      ramstate = RS_BUSY;
      #1; @(negedge clk);
      #1;
      vectors++;
      if (ram_ren !== 1'b1) begin
         miscompares++;
         $display("FAIL wd_grant: got ren %b expected 1", ram_ren);
      end
      @(negedge clk);
      dren[0] = 1'b0;
      #1;
      vectors++;
      if ({ram_ren, iwait, dwait} !== 5'b0_1111) begin
         miscompares++;
         $display("FAIL wd_drop: got %b expected 01111", {ram_ren, iwait, dwait});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({dbg_state, dbg_rr_ptr, iwait, dwait} !== {1'b0, CW'(0), 4'b1111}) begin
         miscompares++;
         $display("FAIL wd_idle: got state %b ptr %0d waits %b expected 0/0/1111", dbg_state, dbg_rr_ptr, {iwait, dwait});
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_error();
      do_reset();
      dren[0] = 1'b1;
      daddr[0 +: AW] = 32'h20;
      ramstate = RS_BUSY;
      #1; @(negedge clk);
      ramstate = RS_ERROR;
      #1;
      vectors++;
      if ({ram_ren, iwait, dwait} !== 5'b1_1111) begin
         miscompares++;
         $display("FAIL err_xfer: got %b expected 11111", {ram_ren, iwait, dwait});
      end
      @(negedge clk);
      dren[0] = 1'b0;
      ramstate = RS_FREE;
      #1;
      vectors++;
      if ({dbg_state, dbg_rr_ptr, iwait, dwait} !== {1'b0, CW'(1), 4'b1111}) begin
         miscompares++;
         $display("FAIL err_idle: got state %b ptr %0d waits %b expected 0/1/1111", dbg_state, dbg_rr_ptr, {iwait, dwait});
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      dren[0] = 1'b1;
      ramstate = RS_BUSY;
`ifdef MEM_TIMEOUT_EN
      for (int c = 0; c < 7; c++) begin
         #1;
         vectors++;
         if (arb_err !== (c == 5)) begin
            miscompares++;
            $display("FAIL tmo_err c%0d: got %b expected %b", c, arb_err, (c == 5));
         end
         if (c == 6) begin
            vectors++;
            if ({dbg_state, dbg_rr_ptr, dwait} !== {1'b0, CW'(1), 2'b11}) begin
               miscompares++;
               $display("FAIL tmo_idle: got state %b ptr %0d dwait %b expected 0/1/11", dbg_state, dbg_rr_ptr, dwait);
            end
         end
         @(negedge clk);
      end
`else
      #1; @(negedge clk);
      for (int c = 1; c < 9; c++) begin
         #1;
         vectors++;
         if ({arb_err, dbg_state, ram_ren, dwait} !== 5'b0_1_1_11) begin
            miscompares++;
            $display("FAIL hold_busy c%0d: got %b expected 01111", c, {arb_err, dbg_state, ram_ren, dwait});
         end
         @(negedge clk);
      end
`endif
      clear_inputs();
   endtask

   // Randomized traffic: cores keep requests up until served; model tracks grant order and completions.
   task automatic test_random(input int cycles);
      int            d_op[NC];
      bit            i_op[NC];
      logic [AW-1:0] c_ia[NC], c_da[NC];
      logic [DW-1:0] c_ds[NC];
      bit            m_busy, m_done, m_abort;
      int            m_core, m_kind, m_ptr, m_wait, r;
      logic [NC-1:0] ew_i, ew_d;
      logic [1:0]    exp_en;
      logic [AW-1:0] exp_addr;
      logic [QW-1:0] got, exp;
      do_reset();
      m_busy = 0; m_ptr = 0; m_core = 0; m_kind = 0; m_wait = 0;
      for (int k = 0; k < NC; k++) begin
         d_op[k] = 0; i_op[k] = 0; c_ia[k] = '0; c_da[k] = '0; c_ds[k] = '0;
      end
      for (int cyc = 0; cyc < cycles; cyc++) begin
         for (int k = 0; k < NC; k++) begin
            if (d_op[k] == 0 && $urandom_range(0, 3) == 0) begin
               d_op[k] = $urandom_range(1, 2);
               c_da[k] = $urandom;
               c_ds[k] = $urandom;
            end
            if (!i_op[k] && $urandom_range(0, 3) == 0) begin
               i_op[k] = 1;
               c_ia[k] = $urandom;
            end
            dren[k] = (d_op[k] == 1);
            dwen[k] = (d_op[k] == 2);
            iren[k] = i_op[k];
            daddr[k*AW +: AW]  = c_da[k];
            dstore[k*DW +: DW] = c_ds[k];
            iaddr[k*AW +: AW]  = c_ia[k];
         end
         r = $urandom_range(0, 9);
         if (m_busy) ramstate = (r < 5) ? RS_ACCESS : (r < 9) ? RS_BUSY : RS_ERROR;
         else        ramstate = 2'(r % 4);
         ramload = $urandom;
         #1;
`ifdef MEM_TIMEOUT_EN
         m_abort = m_busy && (m_wait == TMO);
`else
         m_abort = 0;
`endif
         m_done = m_busy && !m_abort && (ramstate == RS_ACCESS);
         ew_i = '1; ew_d = '1;
         if (m_done) begin
            if (m_kind == 3) ew_i[m_core] = 1'b0;
            else             ew_d[m_core] = 1'b0;
         end
         exp_en   = !m_busy ? 2'b00 : (m_kind == 2) ? 2'b01 : 2'b10;
         exp_addr = (m_kind == 3) ? c_ia[m_core] : c_da[m_core];
         vectors++;
         if ({iwait, dwait} !== {ew_i, ew_d}) begin
            miscompares++;
            $display("FAIL rnd_wait cyc%0d: got %b expected %b", cyc, {iwait, dwait}, {ew_i, ew_d});
         end
         vectors++;
         if ({ram_ren, ram_wen} !== exp_en) begin
            miscompares++;
            $display("FAIL rnd_en cyc%0d: got %b expected %b", cyc, {ram_ren, ram_wen}, exp_en);
         end
         if (m_busy) begin
            vectors++;
            if (ramaddr !== exp_addr) begin
               miscompares++;
               $display("FAIL rnd_addr cyc%0d: got %h expected %h", cyc, ramaddr, exp_addr);
            end
            if (m_kind == 2) begin
               vectors++;
               if (ramstore !== c_ds[m_core]) begin
                  miscompares++;
                  $display("FAIL rnd_store cyc%0d: got %h expected %h", cyc, ramstore, c_ds[m_core]);
               end
            end
         end
         vectors++;
         if ({iload, dload} !== {{NC{ramload}}, {NC{ramload}}}) begin
            miscompares++;
            $display("FAIL rnd_load cyc%0d: got %h/%h expected %h", cyc, iload, dload, ramload);
         end
         vectors++;
         if (arb_err !== m_abort) begin
            miscompares++;
            $display("FAIL rnd_arb_err cyc%0d: got %b expected %b", cyc, arb_err, m_abort);
         end
         // Scoreboard: each released wait must match the oldest predicted completion.
         if (m_done) exp_q.push_back({m_kind == 2, exp_addr, (m_kind == 2) ? c_ds[m_core] : DW'(0)});
         if (iwait !== '1 || dwait !== '1) begin
            got = {ram_wen, ramaddr, ram_wen ? ramstore : DW'(0)};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rnd_sb_extra cyc%0d: got completion %h expected none", cyc, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  miscompares++;
                  $display("FAIL rnd_sb cyc%0d: got %h expected %h", cyc, got, exp);
               end
            end
         end
         if (!m_busy) begin
            for (int j = 0; j < NC; j++) begin
               int k;
               k = (m_ptr + j) % NC;
               if (!m_busy && (d_op[k] != 0 || i_op[k])) begin
                  m_busy = 1;
                  m_core = k;
                  m_kind = (d_op[k] == 1) ? 1 : (d_op[k] == 2) ? 2 : 3;
                  m_wait = 0;
               end
            end
         end else if (m_abort || ramstate == RS_ACCESS || ramstate == RS_ERROR) begin
            if (m_done) begin
               if (m_kind == 3) i_op[m_core] = 0;
               else             d_op[m_core] = 0;
            end
            m_busy = 0;
            m_ptr  = (m_core + 1) % NC;
         end else begin
            m_wait++;
         end
         @(negedge clk);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rnd_sb_left: got %0d unmatched completions expected 0", exp_q.size());
      end
      clear_inputs();
   endtask

   // Sequence and final report
   initial begin
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_reset_mid_xfer();
      test_round_robin();
      test_type_priority();
      test_withdrawal();
      test_error();
      test_timeout();
      test_random(2000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
